eth_tx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 27 ++
 rtl/eth_tx_framer_if.sv | 17 +
 rtl/crc32_d8.sv | 25 ++
 rtl/eth_tx_framer.sv | 175 +++++++++++++++++
 tb/tb_eth_tx_framer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_pkg : shared Ethernet TX constants and framer state encoding. Rev 1.0 |
// +--------------------------------------------------------------------------+
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
    localparam logic [7:0]  ETH_SFD        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;

    localparam int ETH_MIN_LEN_DEF = 60;
    localparam int ETH_MAX_LEN_DEF = 1514;
    localparam int ETH_IFG_LEN_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } framer_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_tx_framer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_tx_framer_if : source byte stream in, GMII TXD/TX_EN out. Rev 1.0     |
// +--------------------------------------------------------------------------+
interface eth_tx_framer_if;

    logic [7:0] i_data;
    logic       i_data_vl;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_tx_en;

    modport master (output i_data, i_data_vl, input  o_ready, o_data, o_tx_en);
    modport slave  (input  i_data, i_data_vl, output o_ready, o_data, o_tx_en);

endinterface
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crc32_d8 : combinational reflected CRC-32 update for one byte. Rev 1.0    |
// +--------------------------------------------------------------------------+
module crc32_d8
    import eth_pkg::*;
(
    input  wire logic [31:0] i_crc,
    input  wire logic [7:0]  i_byte,
    output logic      [31:0] o_crc
);

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
        end
        return c;
    endfunction

    assign o_crc = crc_step(i_crc, i_byte);

endmodule
`default_nettype wire

// File: rtl/eth_tx_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_tx_framer : adds preamble/SFD, padding, FCS and IFG to a raw frame.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter bit PAD_EN  = 1'b1,
    parameter int MIN_LEN = ETH_MIN_LEN_DEF,
    parameter int MAX_LEN = ETH_MAX_LEN_DEF,
    parameter int IFG_LEN = ETH_IFG_LEN_DEF
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    eth_tx_framer_if.slave          bus,
    output logic             [15:0] o_frame_cnt,
    output logic             [15:0] o_drop_cnt,
    output logic                    o_trunc
);

    localparam logic [15:0] c_min_len  = 16'(MIN_LEN);
    localparam logic [15:0] c_max_len  = 16'(MAX_LEN);
    localparam logic [15:0] c_ifg_last = 16'(IFG_LEN - 1);

    framer_state_e state_q;
    logic [7:0]    dl_q [8];
    logic [7:0]    dlv_q;
    logic [15:0]   len_q, emit_cnt_q, ifg_cnt_q;
    logic [2:0]    pre_cnt_q, fcs_idx_q;
    logic          acc_q, run_q, vl_q;
    logic [31:0]   crc_q, crc_d;
    logic [7:0]    data_q;
    logic          tx_en_q, ready_q, trunc_q;
    logic [15:0]   frame_cnt_q, drop_cnt_q;

    logic        w_rise, w_start, w_take, w_need_pad;
    logic [7:0]  w_crc_byte, w_fcs_byte;
    logic [31:0] w_crc_inv;

    assign w_rise     = bus.i_data_vl & ~vl_q;
    assign w_start    = (state_q == ST_IDLE) & w_rise;
    assign w_take     = acc_q & bus.i_data_vl & (len_q < c_max_len);
    assign w_need_pad = PAD_EN && (emit_cnt_q < c_min_len);
    assign w_crc_byte = ((state_q == ST_DATA) && dlv_q[7]) ? dl_q[7] : 8'h00;
    assign w_crc_inv  = ~crc_q;
    assign w_fcs_byte = w_crc_inv[{fcs_idx_q[1:0], 3'b000} +: 8];

    crc32_d8 u_crc (
        .i_crc  (crc_q),
        .i_byte (w_crc_byte),
        .o_crc  (crc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            for (int k = 0; k < 8; k++) dl_q[k] <= 8'h00;
            dlv_q       <= 8'h00;
            len_q       <= 16'd0;
            emit_cnt_q  <= 16'd0;
            ifg_cnt_q   <= 16'd0;
            pre_cnt_q   <= 3'd0;
            fcs_idx_q   <= 3'd0;
            acc_q       <= 1'b0;
            run_q       <= 1'b0;
            vl_q        <= 1'b0;
            crc_q       <= CRC32_INIT;
            data_q      <= 8'h00;
            tx_en_q     <= 1'b0;
            ready_q     <= 1'b1;
            trunc_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            trunc_q <= 1'b0;
            vl_q    <= bus.i_data_vl;

            // Input side runs independently of the output state: the delay
            // line keeps filling during preamble and tags accepted bytes.
            dl_q[0] <= bus.i_data;
            for (int k = 1; k < 8; k++) dl_q[k] <= dl_q[k-1];
            dlv_q   <= {dlv_q[6:0], w_start | w_take};

            if (w_start)     len_q <= 16'd1;
            else if (w_take) len_q <= len_q + 16'd1;

            if (w_start) begin
                acc_q <= 1'b1;
            end else if (!bus.i_data_vl) begin
                acc_q <= 1'b0;
            end else if (acc_q && (len_q == c_max_len)) begin
                acc_q   <= 1'b0;
                trunc_q <= 1'b1;
            end

            if (w_start)              run_q <= 1'b1;
            else if (!bus.i_data_vl)  run_q <= 1'b0;

            if (w_rise && !ready_q) drop_cnt_q <= drop_cnt_q + 16'd1;

            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        data_q    <= ETH_PREAMBLE;
                        tx_en_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        pre_cnt_q <= 3'd0;
                        state_q   <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    data_q    <= ETH_PREAMBLE;
                    pre_cnt_q <= pre_cnt_q + 3'd1;
                    if (pre_cnt_q == 3'd5) state_q <= ST_SFD;
                end
                ST_SFD: begin
                    data_q     <= ETH_SFD;
                    crc_q      <= CRC32_INIT;
                    emit_cnt_q <= 16'd0;
                    fcs_idx_q  <= 3'd0;
                    state_q    <= ST_DATA;
                end
                ST_DATA, ST_PAD: begin
                    if ((state_q == ST_DATA) && dlv_q[7]) begin
                        data_q     <= dl_q[7];
                        crc_q      <= crc_d;
                        emit_cnt_q <= emit_cnt_q + 16'd1;
                    end else if (w_need_pad) begin
                        data_q     <= 8'h00;
                        crc_q      <= crc_d;
                        emit_cnt_q <= emit_cnt_q + 16'd1;
                        state_q    <= ST_PAD;
                    end else begin
                        data_q    <= w_fcs_byte;
                        fcs_idx_q <= 3'd1;
                        state_q   <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    if (fcs_idx_q == 3'd4) begin
                        data_q      <= 8'h00;
                        tx_en_q     <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        ifg_cnt_q   <= 16'd1;
                        state_q     <= ST_IFG;
                    end else begin
                        data_q    <= w_fcs_byte;
                        fcs_idx_q <= fcs_idx_q + 3'd1;
                    end
                end
                ST_IFG: begin
                    // A truncated frame's input run may outlast the gap; stay
                    // unready until it ends so it is not counted as a drop.
                    if ((ifg_cnt_q == c_ifg_last) && !run_q) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (ifg_cnt_q != c_ifg_last) begin
                        ifg_cnt_q <= ifg_cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_tx_en   = tx_en_q;
    assign bus.o_ready   = ready_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_trunc       = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_eth_tx_framer : scoreboard bench, padded and unpadded framers. Rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_eth_tx_framer;
    import eth_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    eth_tx_framer_if ifp ();
    eth_tx_framer_if ifn ();
    logic [15:0] fc_p, dc_p, fc_n, dc_n;
    logic        tr_p, tr_n;

    eth_tx_framer #(.PAD_EN(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .bus(ifp.slave),
        .o_frame_cnt(fc_p), .o_drop_cnt(dc_p), .o_trunc(tr_p));
    eth_tx_framer #(.PAD_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(ifn.slave),
        .o_frame_cnt(fc_n), .o_drop_cnt(dc_n), .o_trunc(tr_n));

    int n_cmp = 0;
    int n_mis = 0;
    byte unsigned exp_p[$], exp_n[$], frame_b[$];
    int  elen_p[$], elen_n[$];
    bit  ign_p = 1'b0, inrun_p = 1'b0, inrun_n = 1'b0, rdy_hi = 1'b0;
    int  run_p = 0, run_n = 0, idle_p = 0, gap_p = 0, trc_p = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sw_crc(input logic [31:0] c_in, input byte unsigned b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else                       c = c >> 1;
        end
        return c;
    endfunction

    task automatic push_b(input bit which, input byte unsigned b);
        if (which) exp_p.push_back(b); else exp_n.push_back(b);
    endtask

    // Reference framing: preamble, (truncated) bytes, optional pad, FCS.
    task automatic push_exp(input bit which, input bit pad);
        logic [31:0] crc;
        int n, total;
        n = (frame_b.size() > 1514) ? 1514 : frame_b.size();
        for (int i = 0; i < 7; i++) push_b(which, 8'h55);
        push_b(which, 8'hD5);
        crc = 32'hFFFFFFFF;
        total = 0;
        for (int i = 0; i < n; i++) begin
            push_b(which, frame_b[i]);
            crc = sw_crc(crc, frame_b[i]);
            total++;
        end
        while (pad && total < 60) begin
            push_b(which, 8'h00);
            crc = sw_crc(crc, 8'h00);
            total++;
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) push_b(which, crc[8*k +: 8]);
        if (which) elen_p.push_back(8 + total + 4); else elen_n.push_back(8 + total + 4);
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        trc_p += int'(tr_p === 1'b1);
        if (ifp.o_tx_en === 1'b1) begin
            if (!inrun_p) begin inrun_p = 1'b1; gap_p = idle_p; run_p = 0; end
            run_p++;
            if (!ign_p) begin
                e = (exp_p.size() > 0) ? {24'h0, exp_p.pop_front()} : 32'hFFFFFFFF;
                chk("p_byte", {24'h0, ifp.o_data}, e);
            end
        end else begin
            if (inrun_p) begin
                inrun_p = 1'b0;
                if (!ign_p) begin
                    e = (elen_p.size() > 0) ? 32'(elen_p.pop_front()) : 32'hFFFFFFFF;
                    chk("p_txen_clocks", 32'(run_p), e);
                end
                idle_p = 0;
            end
            idle_p++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (ifn.o_tx_en === 1'b1) begin
            if (!inrun_n) begin inrun_n = 1'b1; run_n = 0; end
            run_n++;
            e = (exp_n.size() > 0) ? {24'h0, exp_n.pop_front()} : 32'hFFFFFFFF;
            chk("n_byte", {24'h0, ifn.o_data}, e);
        end else if (inrun_n) begin
            inrun_n = 1'b0;
            e = (elen_n.size() > 0) ? 32'(elen_n.pop_front()) : 32'hFFFFFFFF;
            chk("n_txen_clocks", 32'(run_n), e);
        end
    end

    task automatic drive(input bit which, input logic v, input logic [7:0] d);
        if (which) begin ifp.i_data_vl = v; ifp.i_data = d; end
        else       begin ifn.i_data_vl = v; ifn.i_data = d; end
    endtask

    function automatic logic rdy(input bit which);
        return which ? ifp.o_ready : ifn.o_ready;
    endfunction

    // Called at posedge+1; first byte is sampled at the next edge.
    task automatic send(input bit which);
        for (int i = 0; i < frame_b.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                if (rdy(which) === 1'b1) rdy_hi = 1'b1;
            end
            drive(which, 1'b1, frame_b[i]);
        end
        @(posedge clk); #1;
        drive(which, 1'b0, 8'h00);
    endtask

    task automatic wait_ready(input bit which, input int budget);
        for (int i = 0; i < budget && rdy(which) !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk(which ? "p_ready_rise" : "n_ready_rise", {31'h0, rdy(which)}, 32'h1);
    endtask

    task automatic wait_cnt(input bit which, input logic [15:0] target, input int budget);
        for (int i = 0; i < budget && (which ? fc_p : fc_n) !== target; i++) begin
            @(posedge clk); #1;
        end
        chk(which ? "p_frame_cnt" : "n_frame_cnt", {16'h0, which ? fc_p : fc_n}, {16'h0, target});
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_data",   {24'h0, ifp.o_data}, 32'h0);
        chk("rst_o_tx_en",  {31'h0, ifp.o_tx_en}, 32'h0);
        chk("rst_o_ready",  {31'h0, ifp.o_ready}, 32'h1);
        chk("rst_frame_cnt", {16'h0, fc_p}, 32'h0);
        chk("rst_drop_cnt", {16'h0, dc_p}, 32'h0);
        chk("rst_o_trunc",  {31'h0, tr_p}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // "123456789" without padding: known FCS 26 39 F4 CB.
        frame_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < 7; i++) exp_n.push_back(8'h55);
        exp_n.push_back(8'hD5);
        foreach (frame_b[i]) exp_n.push_back(frame_b[i]);
        exp_n.push_back(8'h26); exp_n.push_back(8'h39);
        exp_n.push_back(8'hF4); exp_n.push_back(8'hCB);
        elen_n.push_back(21);
        wait_ready(1'b0, 20);
        send(1'b0);
        wait_cnt(1'b0, 16'd1, 100);

        // 42-byte ARP-like frame, padded to 60.
        frame_b.delete();
        for (int i = 0; i < 42; i++) frame_b.push_back(8'((i * 37 + 5) & 8'hFF));
        push_exp(1'b1, 1'b1);
        wait_ready(1'b1, 20);
        send(1'b1);
        wait_cnt(1'b1, 16'd1, 200);

        // Exactly MIN_LEN, then a source that restarts the cycle after TX_EN falls.
        frame_b.delete();
        for (int i = 0; i < 60; i++) frame_b.push_back(8'(8'hC0 ^ i));
        push_exp(1'b1, 1'b1);
        wait_ready(1'b1, 20);
        send(1'b1);
        wait_cnt(1'b1, 16'd2, 200);
        drive(1'b1, 1'b1, 8'hEE);
        repeat (3) begin @(posedge clk); #1; end
        drive(1'b1, 1'b0, 8'h00);
        chk("drop_cnt", {16'h0, dc_p}, 32'h1);
        frame_b.delete();
        for (int i = 0; i < 20; i++) frame_b.push_back(8'(i + 8'h10));
        push_exp(1'b1, 1'b1);
        wait_ready(1'b1, 40);
        send(1'b1);
        wait_cnt(1'b1, 16'd3, 200);
        chk("ifg_gap", 32'(gap_p), 32'd12);

        // 1600-byte input truncated at MAX_LEN.
        frame_b.delete();
        for (int i = 0; i < 1600; i++) frame_b.push_back(8'((i ^ (i >> 8)) & 8'hFF));
        push_exp(1'b1, 1'b1);
        rdy_hi = 1'b0;
        wait_ready(1'b1, 40);
        send(1'b1);
        chk("ready_low_during_input", {31'h0, rdy_hi}, 32'h0);
        chk("ready_held_at_input_end", {31'h0, ifp.o_ready}, 32'h0);
        chk("trunc_frame_cnt", {16'h0, fc_p}, 32'd4);
        wait_ready(1'b1, 10);
        chk("trunc_pulses", 32'(trc_p), 32'd1);
        chk("drop_cnt_after_trunc", {16'h0, dc_p}, 32'h1);

        // Single-cycle frame 0xAB on both framers.
        frame_b = '{8'hAB};
        push_exp(1'b1, 1'b1);
        push_exp(1'b0, 1'b0);
        send(1'b1);
        wait_cnt(1'b1, 16'd5, 200);
        wait_ready(1'b0, 20);
        send(1'b0);
        wait_cnt(1'b0, 16'd2, 100);

        // Reset at frame byte 20, then a clean frame.
        ign_p = 1'b1;
        wait_ready(1'b1, 40);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            drive(1'b1, 1'b1, 8'(i + 8'h40));
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        chk("midrst_o_tx_en",  {31'h0, ifp.o_tx_en}, 32'h0);
        chk("midrst_o_ready",  {31'h0, ifp.o_ready}, 32'h1);
        chk("midrst_o_data",   {24'h0, ifp.o_data}, 32'h0);
        chk("midrst_frame_cnt", {16'h0, fc_p}, 32'h0);
        chk("midrst_drop_cnt", {16'h0, dc_p}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        ign_p = 1'b0;
        frame_b.delete();
        for (int i = 0; i < 50; i++) frame_b.push_back(8'(8'hFF - i));
        push_exp(1'b1, 1'b1);
        @(posedge clk); #1;
        wait_ready(1'b1, 20);
        send(1'b1);
        wait_cnt(1'b1, 16'd1, 200);
        repeat (4) @(posedge clk);

        chk("p_bytes_left", 32'(exp_p.size()), 32'd0);
        chk("n_bytes_left", 32'(exp_n.size()), 32'd0);
        chk("p_frames_left", 32'(elen_p.size()), 32'd0);
        chk("n_frames_left", 32'(elen_n.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
